// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Grant ids, FSM states and the fixed word-access control fields.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } gnt_t;

    localparam logic [1:0] FUNC_IN_WORD  = 2'b10;
    localparam logic [2:0] FUNC_OUT_WORD = 3'b010;

    typedef struct packed {
        logic       we;
        logic [1:0] func_in;
        logic [2:0] func_out;
    } mem_ctl_t;

    function automatic mem_ctl_t fetch_ctl();
        mem_ctl_t c;
        c.we       = 1'b0;
        c.func_in  = FUNC_IN_WORD;
        c.func_out = FUNC_OUT_WORD;
        return c;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the arbiter.
// slave = arbiter view, master = core/memory environment view.
interface mem_port_arbiter_if #(
    parameter int DATA_W = 32
);

    logic              if_req;
    logic [DATA_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;

    logic              d_req;
    logic              d_we;
    logic [1:0]        d_func_in;
    logic [2:0]        d_func_out;
    logic [DATA_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_func_in;
    logic [2:0]        mem_func_out;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr,
        output if_ack, if_rdata, if_err,
        input  d_req, d_we, d_func_in, d_func_out, d_addr, d_wdata,
        output d_ack, d_rdata, d_err,
        output mem_req, mem_we, mem_func_in, mem_func_out,
        output mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        output busy
    );

    modport master (
        output if_req, if_addr,
        input  if_ack, if_rdata, if_err,
        output d_req, d_we, d_func_in, d_func_out, d_addr, d_wdata,
        input  d_ack, d_rdata, d_err,
        input  mem_req, mem_we, mem_func_in, mem_func_out,
        input  mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        input  busy
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data requesters.
// ARB_ROUND_ROBIN_EN: ties go to the port that did not win last time.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  gnt_t last_grant,
    output gnt_t grant
);

    always_comb begin
        grant = last_grant;
        unique case (1'b1)
            (if_req && d_req): begin
`ifdef ARB_ROUND_ROBIN_EN
                grant = (last_grant == GNT_DATA) ? GNT_FETCH : GNT_DATA;
`else
                grant = GNT_DATA;
`endif
            end
            (d_req && !if_req): grant = GNT_DATA;
            (if_req && !d_req): grant = GNT_FETCH;
            default:            grant = last_grant;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between fetch and load/store.
// Optional round-robin tie break: define ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int DATA_W  = 32
) (
    input  logic clock,
    input  logic reset,
    mem_port_arbiter_if.slave bus
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    gnt_t              gnt;
    gnt_t              last_grant;
    gnt_t              pick;
    logic [CNT_W-1:0]  tcnt;

    mem_ctl_t          d_ctl;
    mem_ctl_t          sel_ctl;
    logic [DATA_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              done;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    mem_arb_pick u_pick (
        .if_req     (bus.if_req),
        .d_req      (bus.d_req),
        .last_grant (last_grant),
        .grant      (pick)
    );

    assign d_ctl = '{
        we:       bus.d_we,
        func_in:  bus.d_func_in,
        func_out: bus.d_func_out
    };

    assign sel_ctl   = (pick == GNT_DATA) ? d_ctl : fetch_ctl();
    assign sel_addr  = (pick == GNT_DATA) ? bus.d_addr : bus.if_addr;
    assign sel_wdata = (pick == GNT_DATA) ? bus.d_wdata : '0;

    // A late mem_ack on the final allowed cycle still counts as success.
    assign done      = bus.mem_ack || (tcnt == T_LAST);
    assign rsp_rdata = bus.mem_ack ? bus.mem_rdata : '0;
    assign rsp_err   = !bus.mem_ack;

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= ST_IDLE;
            gnt              <= GNT_FETCH;
            last_grant       <= GNT_FETCH;
            tcnt             <= '0;
            bus.if_ack       <= 1'b0;
            bus.if_rdata     <= '0;
            bus.if_err       <= 1'b0;
            bus.d_ack        <= 1'b0;
            bus.d_rdata      <= '0;
            bus.d_err        <= 1'b0;
            bus.mem_req      <= 1'b0;
            bus.mem_we       <= 1'b0;
            bus.mem_func_in  <= '0;
            bus.mem_func_out <= '0;
            bus.mem_addr     <= '0;
            bus.mem_wdata    <= '0;
            bus.busy         <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.if_req || bus.d_req) begin
                        state            <= ST_BUSY;
                        gnt              <= pick;
                        tcnt             <= '0;
                        bus.busy         <= 1'b1;
                        bus.mem_req      <= 1'b1;
                        bus.mem_we       <= sel_ctl.we;
                        bus.mem_func_in  <= sel_ctl.func_in;
                        bus.mem_func_out <= sel_ctl.func_out;
                        bus.mem_addr     <= sel_addr;
                        bus.mem_wdata    <= sel_wdata;
                    end
                end
                ST_BUSY: begin
                    if (done) begin
                        state       <= ST_RESP;
                        bus.mem_req <= 1'b0;
                        if (gnt == GNT_DATA) begin
                            bus.d_ack   <= 1'b1;
                            bus.d_rdata <= rsp_rdata;
                            bus.d_err   <= rsp_err;
                        end else begin
                            bus.if_ack   <= 1'b1;
                            bus.if_rdata <= rsp_rdata;
                            bus.if_err   <= rsp_err;
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    state        <= ST_IDLE;
                    last_grant   <= gnt;
                    bus.busy     <= 1'b0;
                    bus.if_ack   <= 1'b0;
                    bus.if_rdata <= '0;
                    bus.if_err   <= 1'b0;
                    bus.d_ack    <= 1'b0;
                    bus.d_rdata  <= '0;
                    bus.d_err    <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Tie-break expectations follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_port_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mem_port_arbiter_if #(.DATA_W(32)) bus ();

    mem_port_arbiter #(
        .TIMEOUT (16),
        .DATA_W  (32)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_d;
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.d_req      = 1'b0;
        bus.d_we       = 1'b0;
        bus.d_func_in  = '0;
        bus.d_func_out = '0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = '0;
        step();
        step();

        chk("rst_if_ack", bus.if_ack, 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_if_err", bus.if_err, 0);
        chk("rst_d_ack", bus.d_ack, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);
        chk("rst_d_err", bus.d_err, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_func_in", bus.mem_func_in, 0);
        chk("rst_func_out", bus.mem_func_out, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_busy", bus.busy, 0);

        rst = 1'b0;
        step();

        // 1: fetch only, two wait cycles, ack four cycles after request
        bus.d_wdata = 32'hFFFF_FFFF;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        step();
        chk("t1_mem_req", bus.mem_req, 1);
        chk("t1_mem_addr", bus.mem_addr, 32'h10);
        chk("t1_mem_we", bus.mem_we, 0);
        chk("t1_func_in", bus.mem_func_in, 2'b10);
        chk("t1_func_out", bus.mem_func_out, 3'b010);
        chk("t1_wdata", bus.mem_wdata, 0);
        chk("t1_busy", bus.busy, 1);
        step();
        chk("t1_no_ack_c2", bus.if_ack, 0);
        step();
        chk("t1_no_ack_c3", bus.if_ack, 0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0050_0093;
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        chk("t1_if_ack", bus.if_ack, 1);
        chk("t1_if_rdata", bus.if_rdata, 32'h0050_0093);
        chk("t1_if_err", bus.if_err, 0);
        chk("t1_d_ack", bus.d_ack, 0);
        chk("t1_mem_req_drop", bus.mem_req, 0);
        chk("t1_busy_resp", bus.busy, 1);
        bus.if_req = 1'b0;
        step();
        chk("t1_ack_gone", bus.if_ack, 0);
        chk("t1_rdata_gone", bus.if_rdata, 0);
        chk("t1_idle", bus.busy, 0);

        // 2: simultaneous load and fetch, data first
        bus.d_req      = 1'b1;
        bus.d_we       = 1'b0;
        bus.d_addr     = 32'h100;
        bus.d_func_in  = 2'b01;
        bus.d_func_out = 3'b100;
        bus.d_wdata    = 32'h1111_2222;
        bus.if_req     = 1'b1;
        bus.if_addr    = 32'h20;
        step();
        chk("t2_addr_d", bus.mem_addr, 32'h100);
        chk("t2_we", bus.mem_we, 0);
        chk("t2_func_in", bus.mem_func_in, 2'b01);
        chk("t2_func_out", bus.mem_func_out, 3'b100);
        chk("t2_wdata", bus.mem_wdata, 32'h1111_2222);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hAAAA_0001;
        step();
        bus.mem_ack = 1'b0;
        chk("t2_d_ack", bus.d_ack, 1);
        chk("t2_d_rdata", bus.d_rdata, 32'hAAAA_0001);
        chk("t2_if_ack_0", bus.if_ack, 0);
        bus.d_req = 1'b0;
        step();
        chk("t2_d_ack_gone", bus.d_ack, 0);
        chk("t2_if_ack_idle", bus.if_ack, 0);
        step();
        chk("t2_addr_f", bus.mem_addr, 32'h20);
        chk("t2_f_busy", bus.busy, 1);
        step();
        chk("t2_f_wait", bus.if_ack, 0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1111_0002;
        step();
        bus.mem_ack = 1'b0;
        chk("t2_if_ack", bus.if_ack, 1);
        chk("t2_if_rdata", bus.if_rdata, 32'h1111_0002);
        chk("t2_d_ack_0", bus.d_ack, 0);
        bus.if_req = 1'b0;
        step();

        // 3: repeated ties from a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        bus.if_addr = 32'h200;
        bus.d_addr  = 32'h300;
        bus.d_we    = 1'b0;
        for (int k = 0; k < 6; k++) begin
            exp_d = RR ? (k % 2 == 0) : 1'b1;
            bus.if_req = 1'b1;
            bus.d_req  = 1'b1;
            step();
            chk($sformatf("t3_addr_%0d", k), bus.mem_addr,
                exp_d ? 32'h300 : 32'h200);
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'(k);
            step();
            bus.mem_ack = 1'b0;
            chk($sformatf("t3_d_ack_%0d", k), bus.d_ack, 32'(exp_d));
            chk($sformatf("t3_if_ack_%0d", k), bus.if_ack, 32'(!exp_d));
            if (exp_d) bus.d_req = 1'b0;
            else       bus.if_req = 1'b0;
            step();
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        step();
        chk("t3_idle", bus.busy, 0);

        // 4: store, fields held through BUSY despite input changes
        bus.d_req      = 1'b1;
        bus.d_we       = 1'b1;
        bus.d_addr     = 32'h40;
        bus.d_wdata    = 32'hDEAD_BEEF;
        bus.d_func_in  = 2'b10;
        bus.d_func_out = 3'b000;
        step();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t4_req_%0d", i), bus.mem_req, 1);
            chk($sformatf("t4_we_%0d", i), bus.mem_we, 1);
            chk($sformatf("t4_addr_%0d", i), bus.mem_addr, 32'h40);
            chk($sformatf("t4_wdata_%0d", i), bus.mem_wdata, 32'hDEAD_BEEF);
            chk($sformatf("t4_fin_%0d", i), bus.mem_func_in, 2'b10);
            chk($sformatf("t4_ack0_%0d", i), bus.d_ack, 0);
            bus.d_addr  = 32'h44;
            bus.d_wdata = 32'h0;
            bus.d_we    = 1'b0;
            step();
        end
        chk("t4_we_last", bus.mem_we, 1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        step();
        bus.mem_ack = 1'b0;
        chk("t4_d_ack", bus.d_ack, 1);
        chk("t4_d_err", bus.d_err, 0);
        chk("t4_d_rdata", bus.d_rdata, 32'h1234_5678);
        chk("t4_mem_req_drop", bus.mem_req, 0);
        bus.d_req = 1'b0;
        step();

        // 5a: no mem_ack, timeout after exactly 16 BUSY cycles
        bus.d_req     = 1'b1;
        bus.d_addr    = 32'h80;
        bus.mem_rdata = 32'hBAD0_BAD0;
        step();
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("t5_req_c%0d", i), bus.mem_req, 1);
            chk($sformatf("t5_ack0_c%0d", i), bus.d_ack, 0);
            step();
        end
        chk("t5_req_c16", bus.mem_req, 1);
        chk("t5_ack0_c16", bus.d_ack, 0);
        step();
        chk("t5_to_ack", bus.d_ack, 1);
        chk("t5_to_err", bus.d_err, 1);
        chk("t5_to_rdata", bus.d_rdata, 0);
        chk("t5_to_req", bus.mem_req, 0);
        bus.d_req = 1'b0;
        step();
        chk("t5_ack_gone", bus.d_ack, 0);
        chk("t5_err_gone", bus.d_err, 0);

        // 5b: mem_ack on the 16th cycle beats the timeout
        bus.d_req = 1'b1;
        step();
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("t5b_ack0_c%0d", i), bus.d_ack, 0);
            step();
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hCAFE_0016;
        step();
        bus.mem_ack = 1'b0;
        chk("t5b_ack", bus.d_ack, 1);
        chk("t5b_err", bus.d_err, 0);
        chk("t5b_rdata", bus.d_rdata, 32'hCAFE_0016);
        bus.d_req = 1'b0;
        step();

        // 6: reset during BUSY, then stray mem_ack in IDLE
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h90;
        step();
        chk("t6_busy", bus.busy, 1);
        chk("t6_req", bus.mem_req, 1);
        rst = 1'b1;
        step();
        chk("t6_rst_req", bus.mem_req, 0);
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_ack", bus.d_ack, 0);
        rst           = 1'b0;
        bus.d_req     = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h77;
        step();
        chk("t6_stray_d_ack", bus.d_ack, 0);
        chk("t6_stray_if_ack", bus.if_ack, 0);
        chk("t6_stray_busy", bus.busy, 0);
        chk("t6_stray_req", bus.mem_req, 0);
        chk("t6_stray_rdata", bus.d_rdata, 0);
        bus.mem_ack = 1'b0;
        step();
        step();
        chk("t6_late_d_ack", bus.d_ack, 0);
        chk("t6_late_if_ack", bus.if_ack, 0);
        chk("t6_late_busy", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
